// File: rtl/sysbus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the 32-bit sysbus io port.
// Latency: 1 cycle from master valid (IDLE) to slave valid; ready/rdata back to masters are combinational.
// Backpressure: a granted master waits on sysbus_i_io_ready; an ungranted master waits in IDLE arbitration.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   m0_io_* / m1_io_*            master request (valid/write/addr/data) and response (ready/rdata)
//   sysbus_o_io_*                request towards the single slave
//   sysbus_i_io_ready/_data      slave response
//   grant                        one-hot grant, 2'b00 while idle
//   timeout_err                  sticky watchdog flag
//
// Optional feature: define SYSBUS_ARB_TIMEOUT_EN to build the watchdog that
// completes a transaction the slave never acknowledges. Without it BUSY waits
// forever and timeout_err is tied low.
module sysbus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_io_valid,
  input  logic        m0_io_write,
  input  logic [31:0] m0_io_addr,
  input  logic [31:0] m0_io_data,
  output logic        m0_io_ready,
  output logic [31:0] m0_io_rdata,

  input  logic        m1_io_valid,
  input  logic        m1_io_write,
  input  logic [31:0] m1_io_addr,
  input  logic [31:0] m1_io_data,
  output logic        m1_io_ready,
  output logic [31:0] m1_io_rdata,

  output logic        sysbus_o_io_valid,
  output logic        sysbus_o_io_write,
  output logic [31:0] sysbus_o_io_addr,
  output logic [31:0] sysbus_o_io_data,
  input  logic        sysbus_i_io_ready,
  input  logic [31:0] sysbus_i_io_data,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;   // master served most recently; the other wins a tie
  logic        wd_hit;           // watchdog expires this cycle (slave ready is 0)
  logic        done;             // current BUSY transaction completes this cycle
  logic [31:0] resp_data;

`ifdef SYSBUS_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  assign wd_hit = (state_q != IDLE) && !sysbus_i_io_ready && (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q | wd_hit;
    if (state_q == IDLE) begin
      wd_cnt_d = '0;
    end else if (!sysbus_i_io_ready) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A real slave ready always beats the watchdog, since wd_hit needs ready low.
  assign done      = sysbus_i_io_ready | wd_hit;
  assign resp_data = wd_hit ? TIMEOUT_RDATA : sysbus_i_io_data;

  always_comb begin
    state_d           = state_q;
    last_d            = last_q;
    m0_io_ready       = 1'b0;
    m0_io_rdata       = '0;
    m1_io_ready       = 1'b0;
    m1_io_rdata       = '0;
    sysbus_o_io_valid = 1'b0;
    sysbus_o_io_write = 1'b0;
    sysbus_o_io_addr  = '0;
    sysbus_o_io_data  = '0;
    grant             = 2'b00;

    case (state_q)
      IDLE: begin
        if (m0_io_valid && m1_io_valid) begin
          state_d = last_q ? BUSY_M0 : BUSY_M1;
        end else if (m0_io_valid) begin
          state_d = BUSY_M0;
        end else if (m1_io_valid) begin
          state_d = BUSY_M1;
        end
      end

      BUSY_M0: begin
        // Fields keep forwarding even if the master illegally drops valid.
        sysbus_o_io_valid = 1'b1;
        sysbus_o_io_write = m0_io_write;
        sysbus_o_io_addr  = m0_io_addr;
        sysbus_o_io_data  = m0_io_data;
        grant             = 2'b01;
        m0_io_rdata       = resp_data;
        m0_io_ready       = done;
        if (done) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end

      BUSY_M1: begin
        sysbus_o_io_valid = 1'b1;
        sysbus_o_io_write = m1_io_write;
        sysbus_o_io_addr  = m1_io_addr;
        sysbus_o_io_data  = m1_io_data;
        grant             = 2'b10;
        m1_io_rdata       = resp_data;
        m1_io_ready       = done;
        if (done) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter: per-cycle vector table plus
// hand-written reset and stall/watchdog sequences; completions are matched
// against a queue of expected responses.
module tb_sysbus_arbiter;

  localparam logic [31:0] M0_ADDR = 32'h0000_1000;
  localparam logic [31:0] M0_DATA = 32'h1111_2222;
  localparam logic [31:0] M1_ADDR = 32'h8000_0004;
  localparam logic [31:0] M1_DATA = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_io_valid = 1'b0, m0_io_write = 1'b0;
  logic [31:0] m0_io_addr = M0_ADDR, m0_io_data = M0_DATA;
  logic        m0_io_ready;
  logic [31:0] m0_io_rdata;
  logic        m1_io_valid = 1'b0, m1_io_write = 1'b0;
  logic [31:0] m1_io_addr = M1_ADDR, m1_io_data = M1_DATA;
  logic        m1_io_ready;
  logic [31:0] m1_io_rdata;
  logic        sysbus_o_io_valid, sysbus_o_io_write;
  logic [31:0] sysbus_o_io_addr, sysbus_o_io_data;
  logic        sysbus_i_io_ready = 1'b0;
  logic [31:0] sysbus_i_io_data = 32'h0;
  logic [1:0]  grant;
  logic        timeout_err;

  always #5 clk = ~clk;

  sysbus_arbiter #(
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_RDATA (32'hDEADBEEF)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .m0_io_valid      (m0_io_valid),
    .m0_io_write      (m0_io_write),
    .m0_io_addr       (m0_io_addr),
    .m0_io_data       (m0_io_data),
    .m0_io_ready      (m0_io_ready),
    .m0_io_rdata      (m0_io_rdata),
    .m1_io_valid      (m1_io_valid),
    .m1_io_write      (m1_io_write),
    .m1_io_addr       (m1_io_addr),
    .m1_io_data       (m1_io_data),
    .m1_io_ready      (m1_io_ready),
    .m1_io_rdata      (m1_io_rdata),
    .sysbus_o_io_valid(sysbus_o_io_valid),
    .sysbus_o_io_write(sysbus_o_io_write),
    .sysbus_o_io_addr (sysbus_o_io_addr),
    .sysbus_o_io_data (sysbus_o_io_data),
    .sysbus_i_io_ready(sysbus_i_io_ready),
    .sysbus_i_io_data (sysbus_i_io_data),
    .grant            (grant),
    .timeout_err      (timeout_err)
  );

  typedef struct {
    logic        r;
    logic        m0v;
    logic        wr0;
    logic        m1v;
    logic        wr1;
    logic        srdy;
    logic [31:0] sdat;
    logic        evld;
    logic [1:0]  egnt;
    logic [1:0]  erdy;
    logic [31:0] erd;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
  } sb_t;

  vec_t vq[$];
  sb_t  sb[$];
  sb_t  mon_e;
  int   checks = 0;
  int   errors = 0;
  logic exp_terr = 1'b0;

  function automatic vec_t mk(input logic r, input logic m0v, input logic wr0,
                              input logic m1v, input logic wr1, input logic srdy,
                              input logic [31:0] sdat, input logic evld,
                              input logic [1:0] egnt, input logic [1:0] erdy,
                              input logic [31:0] erd);
    vec_t v;
    v.r = r; v.m0v = m0v; v.wr0 = wr0; v.m1v = m1v; v.wr1 = wr1;
    v.srdy = srdy; v.sdat = sdat; v.evld = evld; v.egnt = egnt;
    v.erdy = erdy; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, check just before the rising edge.
  task automatic apply(input vec_t v);
    sb_t         e;
    logic [31:0] ea, ed;
    logic        ew;
    @(negedge clk);
    rst               = v.r;
    m0_io_valid       = v.m0v;
    m0_io_write       = v.wr0;
    m1_io_valid       = v.m1v;
    m1_io_write       = v.wr1;
    sysbus_i_io_ready = v.srdy;
    sysbus_i_io_data  = v.sdat;
    if (v.erdy != 2'b00) begin
      e.id    = v.erdy[1];
      e.rdata = v.erd;
      sb.push_back(e);
    end
    ea = (v.egnt == 2'b01) ? M0_ADDR : (v.egnt == 2'b10) ? M1_ADDR : 32'h0;
    ed = (v.egnt == 2'b01) ? M0_DATA : (v.egnt == 2'b10) ? M1_DATA : 32'h0;
    ew = (v.egnt == 2'b01) ? v.wr0   : (v.egnt == 2'b10) ? v.wr1   : 1'b0;
    #4;
    chk("slave_valid", 32'(sysbus_o_io_valid), 32'(v.evld));
    chk("grant",       32'(grant),             32'(v.egnt));
    chk("m0_ready",    32'(m0_io_ready),       32'(v.erdy[0]));
    chk("m1_ready",    32'(m1_io_ready),       32'(v.erdy[1]));
    chk("slave_write", 32'(sysbus_o_io_write), 32'(ew));
    chk("slave_addr",  sysbus_o_io_addr,       ea);
    chk("slave_data",  sysbus_o_io_data,       ed);
    chk("timeout_err", 32'(timeout_err),       32'(exp_terr));
    if (v.egnt != 2'b01) chk("m0_rdata_idle", m0_io_rdata, 32'h0);
    if (v.egnt != 2'b10) chk("m1_rdata_idle", m1_io_rdata, 32'h0);
  endtask

  // Scoreboard: every completion seen at a master must match the oldest expected one.
  always begin
    @(negedge clk);
    #4;
    if (m0_io_ready === 1'b1 || m1_io_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: completion m0=%b m1=%b with nothing expected", m0_io_ready, m1_io_ready);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_master", 32'(m1_io_ready), 32'(mon_e.id));
        chk("sb_rdata", m1_io_ready ? m1_io_rdata : m0_io_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    logic [1:0] g;

    // m0 read, slave ready in the 3rd BUSY cycle.
    vq.push_back(mk(0, 1,0, 0,0, 0,32'h0,          0,2'b00,2'b00,32'h0));
    vq.push_back(mk(0, 1,0, 0,0, 0,32'h0,          1,2'b01,2'b00,32'h0));
    vq.push_back(mk(0, 1,0, 0,0, 0,32'h0,          1,2'b01,2'b00,32'h0));
    vq.push_back(mk(0, 1,0, 0,0, 1,32'h1234_5678,  1,2'b01,2'b01,32'h1234_5678));
    vq.push_back(mk(0, 0,0, 0,0, 0,32'h0,          0,2'b00,2'b00,32'h0));
    // m1 write; m0 stays quiet.
    vq.push_back(mk(0, 0,0, 1,1, 0,32'h0,          0,2'b00,2'b00,32'h0));
    vq.push_back(mk(0, 0,0, 1,1, 0,32'h0,          1,2'b10,2'b00,32'h0));
    vq.push_back(mk(0, 0,0, 1,1, 1,32'h0000_0077,  1,2'b10,2'b10,32'h0000_0077));
    vq.push_back(mk(0, 0,0, 0,0, 0,32'h0,          0,2'b00,2'b00,32'h0));
    // Continuous contention, slave ready in the first BUSY cycle; m1 served last so m0 leads.
    for (int i = 0; i < 6; i++) begin
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      vq.push_back(mk(0, 1,0, 1,0, 0,32'h0,                1,2'b00,2'b00,32'h0) );
      vq[vq.size()-1].evld = 1'b0;
      vq.push_back(mk(0, 1,0, 1,0, 1,32'hC0DE_0000 + 32'(i), 1,g,g,32'hC0DE_0000 + 32'(i)));
    end
    vq.push_back(mk(0, 0,0, 0,0, 0,32'h0,          0,2'b00,2'b00,32'h0));

    repeat (2) @(negedge clk);

    for (int i = 0; i < vq.size(); i++) apply(vq[i]);

    // Reset during BUSY_M0. First complete an m0 transfer so last points at m0;
    // reset must restore last=1, giving m0 the tie afterwards.
    apply(mk(0, 1,0, 0,0, 0,32'h0,         0,2'b00,2'b00,32'h0));
    apply(mk(0, 1,0, 0,0, 1,32'h0000_0011, 1,2'b01,2'b01,32'h0000_0011));
    apply(mk(0, 0,0, 0,0, 0,32'h0,         0,2'b00,2'b00,32'h0));
    apply(mk(0, 1,0, 0,0, 0,32'h0,         0,2'b00,2'b00,32'h0));
    apply(mk(1, 1,0, 1,0, 0,32'h0,         1,2'b01,2'b00,32'h0));
    apply(mk(0, 1,0, 1,0, 0,32'h0,         0,2'b00,2'b00,32'h0));
    apply(mk(0, 1,0, 1,0, 1,32'h0BAD_0001, 1,2'b01,2'b01,32'h0BAD_0001));
    apply(mk(0, 1,0, 1,0, 0,32'h0,         0,2'b00,2'b00,32'h0));
    apply(mk(0, 1,0, 1,0, 1,32'h0BAD_0002, 1,2'b10,2'b10,32'h0BAD_0002));
    apply(mk(0, 0,0, 0,0, 0,32'h0,         0,2'b00,2'b00,32'h0));

`ifdef SYSBUS_ARB_TIMEOUT_EN
    // Slave never ready: watchdog completes in the 4th BUSY cycle.
    apply(mk(0, 1,0, 0,0, 0,32'h0, 0,2'b00,2'b00,32'h0));
    for (int i = 0; i < 3; i++) apply(mk(0, 1,0, 0,0, 0,32'h0, 1,2'b01,2'b00,32'h0));
    apply(mk(0, 1,0, 0,0, 0,32'h5555_5555, 1,2'b01,2'b01,32'hDEAD_BEEF));
    exp_terr = 1'b1;
    for (int i = 0; i < 3; i++) apply(mk(0, 0,0, 0,0, 0,32'h0, 0,2'b00,2'b00,32'h0));
    apply(mk(1, 0,0, 0,0, 0,32'h0, 0,2'b00,2'b00,32'h0));
    exp_terr = 1'b0;
    apply(mk(0, 0,0, 0,0, 0,32'h0, 0,2'b00,2'b00,32'h0));
    // Slave ready in the 4th BUSY cycle beats the watchdog.
    apply(mk(0, 1,0, 0,0, 0,32'h0, 0,2'b00,2'b00,32'h0));
    for (int i = 0; i < 3; i++) apply(mk(0, 1,0, 0,0, 0,32'h0, 1,2'b01,2'b00,32'h0));
    apply(mk(0, 1,0, 0,0, 1,32'h600D_D00D, 1,2'b01,2'b01,32'h600D_D00D));
    for (int i = 0; i < 2; i++) apply(mk(0, 0,0, 0,0, 0,32'h0, 0,2'b00,2'b00,32'h0));
`else
    // Slave stalls for 1000 cycles: BUSY holds, no error, then a normal completion.
    apply(mk(0, 1,0, 0,0, 0,32'h0, 0,2'b00,2'b00,32'h0));
    for (int i = 0; i < 1000; i++) apply(mk(0, 1,0, 0,0, 0,32'h0, 1,2'b01,2'b00,32'h0));
    apply(mk(0, 1,0, 0,0, 1,32'hA5A5_5A5A, 1,2'b01,2'b01,32'hA5A5_5A5A));
    apply(mk(0, 0,0, 0,0, 0,32'h0, 0,2'b00,2'b00,32'h0));
`endif

    apply(mk(0, 0,0, 0,0, 0,32'h0, 0,2'b00,2'b00,32'h0));
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
